// File: rtl/prf_sweep_pkg.sv
// Shared state encoding, edge codes and saturating increment for the PRF sweep control path.
// Pure declarations: no latency, no backpressure.
package prf_sweep_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARMED,
      ST_UPD,
      ST_RAMP,
      ST_HOLD
   } sweep_state_t;

   localparam logic [1:0] EDGE_RISE = 2'b01;
   localparam logic [1:0] EDGE_FALL = 2'b10;

   // Value is w bits wide, zero-extended; sticks at all-ones of that width.
   function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
      logic [31:0] top;
      top = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      return (v == top) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/sweep_pulse_timer.sv
// Loadable down-counter; done is high in the last cycle of a loaded width of N cycles.
// Latency: load at edge k -> done seen at edge k+N; no backpressure, a new load restarts it.
module sweep_pulse_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst || clr) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - W'(1);
      end
   end

   assign done = (cnt == W'(1));

endmodule

// File: rtl/sweep_trig_ctrl.sv
// PRF/TR edge pairs -> DDS IO_UPDATE, ramp direction and hold; option SWEEP_CT_GATE_EN gates triggers on ct.
// Latency: PRF rise sampled at edge n -> io_update from edge n+1; no backpressure, busy triggers dropped as overlap.
module sweep_trig_ctrl
   import prf_sweep_pkg::*;
#(
   parameter int IO_UPD_CYC = 4,
   parameter int HOLD_CYC   = 2,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic [1:0]       prf_edge,
   input  logic [1:0]       tr_edge,
   input  logic             ct,
   input  logic [CNT_W-1:0] frame_len,
   input  logic             alt_dir,
   output logic             dds_io_update,
   output logic             dds_drctl,
   output logic             dds_drhold,
   output logic             frame_start,
   output logic [CNT_W-1:0] pulse_index,
   output logic [CNT_W-1:0] trig_cnt,
   output logic [CNT_W-1:0] ct_skip_cnt,
   output logic             overlap_err
);

   localparam int UPD_W  = $clog2(IO_UPD_CYC + 1);
   localparam int HOLD_W = $clog2(HOLD_CYC + 1);

   sweep_state_t     state;
   logic             prf_rise, tr_fall, ct_block;
   logic             upd_load, hold_load, upd_done, hold_done;
   logic [CNT_W-1:0] last_idx;

   assign prf_rise = (prf_edge == EDGE_RISE);
   assign tr_fall  = (tr_edge == EDGE_FALL);

`ifdef SWEEP_CT_GATE_EN
   assign ct_block = ct;
`else
   logic unused_ct;
   assign unused_ct = ct;
   assign ct_block  = 1'b0;
`endif

   // frame_len of 0 behaves as a one-pulse frame.
   assign last_idx  = (frame_len == '0) ? '0 : frame_len - CNT_W'(1);

   assign upd_load  = enable && (state == ST_ARMED) && prf_rise && !ct_block;
   assign hold_load = enable && (state == ST_RAMP) && tr_fall;

   sweep_pulse_timer #(.W(UPD_W)) u_upd_timer (
      .clk      (clk),
      .rst      (rst),
      .clr      (!enable),
      .load     (upd_load),
      .load_val (UPD_W'(IO_UPD_CYC)),
      .done     (upd_done)
   );

   sweep_pulse_timer #(.W(HOLD_W)) u_hold_timer (
      .clk      (clk),
      .rst      (rst),
      .clr      (!enable),
      .load     (hold_load),
      .load_val (HOLD_W'(HOLD_CYC)),
      .done     (hold_done)
   );

   always_ff @(posedge clk) begin
      if (!rst || !enable) begin
         state         <= ST_IDLE;
         dds_io_update <= 1'b0;
         dds_drctl     <= 1'b0;
         dds_drhold    <= 1'b0;
         frame_start   <= 1'b0;
         pulse_index   <= '0;
         trig_cnt      <= '0;
         ct_skip_cnt   <= '0;
         overlap_err   <= 1'b0;
      end else begin
         frame_start <= 1'b0;
         if (prf_rise && (state inside {ST_UPD, ST_RAMP, ST_HOLD})) begin
            overlap_err <= 1'b1;
         end
         case (state)
            ST_IDLE: state <= ST_ARMED;
            ST_ARMED: begin
               if (prf_rise) begin
                  if (ct_block) begin
                     ct_skip_cnt <= CNT_W'(sat_inc(32'(ct_skip_cnt), CNT_W));
                  end else begin
                     state         <= ST_UPD;
                     dds_io_update <= 1'b1;
                     dds_drctl     <= alt_dir ? ~pulse_index[0] : 1'b1;
                     frame_start   <= (pulse_index == '0);
                     trig_cnt      <= CNT_W'(sat_inc(32'(trig_cnt), CNT_W));
                  end
               end
            end
            ST_UPD: begin
               if (upd_done) begin
                  state         <= ST_RAMP;
                  dds_io_update <= 1'b0;
               end
            end
            ST_RAMP: begin
               if (tr_fall) begin
                  state      <= ST_HOLD;
                  dds_drhold <= 1'b1;
               end
            end
            ST_HOLD: begin
               if (hold_done) begin
                  state       <= ST_ARMED;
                  dds_drhold  <= 1'b0;
                  dds_drctl   <= 1'b0;
                  pulse_index <= (pulse_index >= last_idx) ? '0 : pulse_index + CNT_W'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sweep_trig_ctrl.sv
// Bench for sweep_trig_ctrl: directed scenarios plus random edges against a countdown-based reference model.
module tb_sweep_trig_ctrl;

   localparam int IO_UPD_CYC = 4;
   localparam int HOLD_CYC   = 2;
   localparam int CNT_W      = 16;
   localparam int MAXV       = (1 << CNT_W) - 1;
`ifdef SWEEP_CT_GATE_EN
   localparam bit GATE = 1'b1;
`else
   localparam bit GATE = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst, enable, ct, alt_dir;
   logic [1:0]       prf_edge, tr_edge;
   logic [CNT_W-1:0] frame_len;
   logic             dds_io_update, dds_drctl, dds_drhold, frame_start, overlap_err;
   logic [CNT_W-1:0] pulse_index, trig_cnt, ct_skip_cnt;

   sweep_trig_ctrl #(.IO_UPD_CYC(IO_UPD_CYC), .HOLD_CYC(HOLD_CYC), .CNT_W(CNT_W)) dut (
      .clk           (clk),
      .rst           (rst),
      .enable        (enable),
      .prf_edge      (prf_edge),
      .tr_edge       (tr_edge),
      .ct            (ct),
      .frame_len     (frame_len),
      .alt_dir       (alt_dir),
      .dds_io_update (dds_io_update),
      .dds_drctl     (dds_drctl),
      .dds_drhold    (dds_drhold),
      .frame_start   (frame_start),
      .pulse_index   (pulse_index),
      .trig_cnt      (trig_cnt),
      .ct_skip_cnt   (ct_skip_cnt),
      .overlap_err   (overlap_err)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_fail = 0, cyc = 0;
   int io_hi = 0, hold_hi = 0, fs_seen = 0;

   // Reference: remaining-cycle counts for each phase of a sweep.
   bit m_idle = 1'b1, m_ramp = 1'b0, m_ovl = 1'b0, m_dir = 1'b0, m_fs = 1'b0;
   int m_io_left = 0, m_hold_left = 0, m_pidx = 0, m_trig = 0, m_skip = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
      end
   endtask

   function automatic int sat(input int v);
      return (v >= MAXV) ? MAXV : v + 1;
   endfunction

   task automatic model_clk();
      int last;
      if (!rst || !enable) begin
         m_idle = 1'b1; m_ramp = 1'b0; m_ovl = 1'b0; m_dir = 1'b0; m_fs = 1'b0;
         m_io_left = 0; m_hold_left = 0; m_pidx = 0; m_trig = 0; m_skip = 0;
         return;
      end
      m_fs = 1'b0;
      if (prf_edge == 2'b01 && (m_io_left > 0 || m_ramp || m_hold_left > 0)) m_ovl = 1'b1;
      if (m_idle) begin
         m_idle = 1'b0;
      end else if (m_io_left > 0) begin
         m_io_left--;
         if (m_io_left == 0) m_ramp = 1'b1;
      end else if (m_ramp) begin
         if (tr_edge == 2'b10) begin
            m_ramp = 1'b0;
            m_hold_left = HOLD_CYC;
         end
      end else if (m_hold_left > 0) begin
         m_hold_left--;
         if (m_hold_left == 0) begin
            m_dir  = 1'b0;
            last   = (frame_len == 0) ? 0 : int'(frame_len) - 1;
            m_pidx = (m_pidx >= last) ? 0 : m_pidx + 1;
         end
      end else if (prf_edge == 2'b01) begin
         if (GATE && ct) begin
            m_skip = sat(m_skip);
         end else begin
            m_io_left = IO_UPD_CYC;
            m_dir     = alt_dir ? ~m_pidx[0] : 1'b1;
            m_fs      = (m_pidx == 0);
            m_trig    = sat(m_trig);
         end
      end
   endtask

   task automatic step(input logic r, input logic e, input logic [1:0] p, input logic [1:0] t,
                       input logic c);
      rst = r; enable = e; prf_edge = p; tr_edge = t; ct = c;
      @(posedge clk);
      model_clk();
      #1;
      cyc++;
      chk("io_update",   32'(dds_io_update), 32'(m_io_left > 0));
      chk("drctl",       32'(dds_drctl),     32'(m_dir));
      chk("drhold",      32'(dds_drhold),    32'(m_hold_left > 0));
      chk("frame_start", 32'(frame_start),   32'(m_fs));
      chk("pulse_index", 32'(pulse_index),   32'(m_pidx));
      chk("trig_cnt",    32'(trig_cnt),      32'(m_trig));
      chk("ct_skip_cnt", 32'(ct_skip_cnt),   32'(m_skip));
      chk("overlap_err", 32'(overlap_err),   32'(m_ovl));
      io_hi   += int'(dds_io_update);
      hold_hi += int'(dds_drhold);
      fs_seen += int'(frame_start);
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b1, 1'b1, 2'b00, 2'b00, 1'b0);
   endtask

   task automatic restart();
      step(1'b0, 1'b1, 2'b00, 2'b00, 1'b0);
      step(1'b1, 1'b1, 2'b00, 2'b00, 1'b0);
      io_hi = 0; hold_hi = 0; fs_seen = 0;
   endtask

   task automatic sweep(input logic c, input int gap);
      step(1'b1, 1'b1, 2'b01, 2'b00, c);
      idle(gap);
      step(1'b1, 1'b1, 2'b00, 2'b10, c);
      idle(HOLD_CYC + 2);
   endtask

   initial begin
      logic [7:0] dir_v, fs_v, exp_dir, exp_fs;
      rst = 1'b0; enable = 1'b0; prf_edge = 2'b00; tr_edge = 2'b00; ct = 1'b0;
      frame_len = 16'd4; alt_dir = 1'b0;

      step(1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
      chk("reset_trig_cnt", 32'(trig_cnt), 32'd0);
      chk("reset_io_update", 32'(dds_io_update), 32'd0);

      // Single sweep with a long ramp.
      restart();
      step(1'b1, 1'b1, 2'b01, 2'b00, 1'b0);
      chk("t1_drctl_up", 32'(dds_drctl), 32'd1);
      idle(50);
      step(1'b1, 1'b1, 2'b00, 2'b10, 1'b0);
      idle(4);
      chk("t1_io_cycles", 32'(io_hi), 32'd4);
      chk("t1_hold_cycles", 32'(hold_hi), 32'd2);
      chk("t1_pulse_index", 32'(pulse_index), 32'd1);

      // Eight periods, 3-pulse frame, alternating direction.
      restart();
      frame_len = 16'd3; alt_dir = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 1'b1, 2'b01, 2'b00, 1'b0);
         dir_v[i] = dds_drctl;
         fs_v[i]  = frame_start;
         idle(6);
         step(1'b1, 1'b1, 2'b00, 2'b10, 1'b0);
         idle(4);
      end
      exp_dir = 8'b0110_1101;
      exp_fs  = 8'b0100_1001;
      chk("t2_drctl_seq", 32'(dir_v), 32'(exp_dir));
      chk("t2_frame_start_seq", 32'(fs_v), 32'(exp_fs));
      chk("t2_trig_cnt", 32'(trig_cnt), 32'd8);

      // Retrigger while io_update is active.
      restart();
      frame_len = 16'd4; alt_dir = 1'b0;
      step(1'b1, 1'b1, 2'b01, 2'b00, 1'b0);
      idle(1);
      step(1'b1, 1'b1, 2'b01, 2'b00, 1'b0);
      chk("t3_overlap_set", 32'(overlap_err), 32'd1);
      idle(4);
      step(1'b1, 1'b1, 2'b00, 2'b10, 1'b0);
      idle(4);
      chk("t3_overlap_sticky", 32'(overlap_err), 32'd1);
      chk("t3_trig_cnt", 32'(trig_cnt), 32'd1);
      chk("t3_io_cycles", 32'(io_hi), 32'd4);

      // Triggers inside the calibration window.
      restart();
      repeat (3) sweep(1'b1, 6);
      chk("t4_ct_skip_cnt", 32'(ct_skip_cnt), GATE ? 32'd3 : 32'd0);
      chk("t4_trig_cnt", 32'(trig_cnt), GATE ? 32'd0 : 32'd3);
      chk("t4_io_cycles", 32'(io_hi), GATE ? 32'd0 : 32'd12);

      // Reset and disable during RAMP.
      restart();
      step(1'b1, 1'b1, 2'b01, 2'b00, 1'b0);
      idle(6);
      step(1'b0, 1'b1, 2'b00, 2'b00, 1'b0);
      chk("t5_rst_drctl", 32'(dds_drctl), 32'd0);
      chk("t5_rst_trig_cnt", 32'(trig_cnt), 32'd0);
      idle(1);
      step(1'b1, 1'b1, 2'b01, 2'b00, 1'b0);
      chk("t5_rst_frame_start", 32'(frame_start), 32'd1);
      idle(6);
      step(1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
      chk("t5_dis_drctl", 32'(dds_drctl), 32'd0);
      chk("t5_dis_trig_cnt", 32'(trig_cnt), 32'd0);
      idle(1);
      step(1'b1, 1'b1, 2'b01, 2'b00, 1'b0);
      chk("t5_dis_frame_start", 32'(frame_start), 32'd1);

      // Zero-length frame.
      restart();
      frame_len = 16'd0;
      repeat (3) sweep(1'b0, 6);
      chk("t6_frame_starts", 32'(fs_seen), 32'd3);
      chk("t6_pulse_index", 32'(pulse_index), 32'd0);

      // Random edges, gating, resets and frame changes.
      restart();
      for (int i = 0; i < 4000; i++) begin
         logic r, e, c;
         logic [1:0] p, t;
         if ($urandom_range(0, 99) == 0) frame_len = 16'($urandom_range(0, 5));
         if ($urandom_range(0, 99) == 0) alt_dir = 1'($urandom_range(0, 1));
         r = ($urandom_range(0, 299) != 0);
         e = ($urandom_range(0, 199) != 0);
         c = ($urandom_range(0, 3) == 0);
         p = ($urandom_range(0, 7) == 0) ? 2'b01 : 2'($urandom_range(0, 2) << 1 | 0) | 2'($urandom_range(0, 1));
         if (p == 2'b01 && $urandom_range(0, 1) == 1) p = 2'b00;
         t = ($urandom_range(0, 5) == 0) ? 2'b10 : 2'($urandom_range(0, 1)) | 2'b00;
         step(r, e, p, t, c);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
